// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit that drives the dm data-memory port with one word beat or a run of byte beats.
// Optional feature macro: DM_LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of splitting them.
module dm_lsu #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [2:0]        mem_type,
    output logic              mem_wr,
    input  logic [31:0]       mem_dout
);

    typedef enum logic [1:0] {IDLE, BEAT, DRAIN, RESP} state_e;

    state_e            state_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [31:0]       wdata_q;
    logic              word_q;
    logic [1:0]        beat_q;
    logic [1:0]        last_q;
    logic [31:0]       rdata_q;

    logic              hs_s;
    logic              illegal_s;
    logic              trap_s;
    logic              word_beat_s;
    logic [1:0]        last_s;
    logic [1:0]        beat_nx_s;
    logic [1:0]        cap_idx_s;
    logic [31:0]       raw_s;

    function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] d);
        case (t)
            3'd1:    extend = {{16{d[15]}}, d[15:0]};
            3'd2:    extend = {16'h0000, d[15:0]};
            3'd3:    extend = {{24{d[7]}}, d[7:0]};
            3'd4:    extend = {24'h000000, d[7:0]};
            default: extend = d;
        endcase
    endfunction

`ifdef DM_LSU_MISALIGN_TRAP_EN
    assign trap_s = ((req_type == 3'd0) && (req_addr[1:0] != 2'd0)) ||
                    (((req_type == 3'd1) || (req_type == 3'd2)) && req_addr[0]);
`else
    assign trap_s = 1'b0;
`endif

    // Request decode, beat indexing and merge of the byte returned by the memory.
    always_comb begin
        hs_s        = req_valid && req_ready;
        illegal_s   = (req_type > 3'd4);
        word_beat_s = (req_type == 3'd0) && (req_addr[1:0] == 2'd0);
        case (req_type)
            3'd0:       last_s = word_beat_s ? 2'd0 : 2'd3;
            3'd1, 3'd2: last_s = 2'd1;
            default:    last_s = 2'd0;
        endcase
        beat_nx_s = beat_q + 2'd1;
        // The byte on mem_dout belongs to the beat driven one cycle earlier.
        cap_idx_s = (state_q == DRAIN) ? last_q : (beat_q - 2'd1);
        if (word_q) begin
            raw_s = mem_dout;
        end else begin
            raw_s = rdata_q;
            raw_s[{cap_idx_s, 3'b000} +: 8] = mem_dout[7:0];
        end
    end

    // Control FSM with all handshake and memory-port outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= 32'h0000_0000;
            mem_type  <= 3'd0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            type_q    <= 3'd0;
            wdata_q   <= 32'h0000_0000;
            word_q    <= 1'b0;
            beat_q    <= 2'd0;
            last_q    <= 2'd0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_s) begin
                        req_ready <= 1'b0;
                        wr_q      <= req_wr;
                        addr_q    <= req_addr;
                        type_q    <= req_type;
                        wdata_q   <= req_wdata;
                        word_q    <= word_beat_s;
                        beat_q    <= 2'd0;
                        last_q    <= last_s;
                        rdata_q   <= 32'h0000_0000;
                        if (illegal_s || trap_s) begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_q  <= BEAT;
                            mem_addr <= req_addr;
                            mem_type <= word_beat_s ? 3'd0 : 3'd3;
                            mem_din  <= word_beat_s ? req_wdata : {24'h000000, req_wdata[7:0]};
                            mem_wr   <= req_wr;
                        end
                    end
                end
                BEAT: begin
                    if (!wr_q && !word_q && (beat_q != 2'd0)) begin
                        rdata_q <= raw_s;
                    end
                    if (beat_q == last_q) begin
                        mem_wr   <= 1'b0;
                        mem_addr <= '0;
                        mem_din  <= 32'h0000_0000;
                        mem_type <= 3'd0;
                        if (wr_q) begin
                            state_q   <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        beat_q   <= beat_nx_s;
                        mem_addr <= addr_q + ADDR_W'(beat_nx_s);
                        mem_din  <= {24'h000000, wdata_q[{beat_nx_s, 3'b000} +: 8]};
                    end
                end
                DRAIN: begin
                    state_q   <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= extend(type_q, raw_s);
                end
                RESP: begin
                    state_q   <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0000_0000;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// tb_dm_lsu: randomized self-checking bench for dm_lsu with a byte-array memory model and a transaction-level reference.
// Honours DM_LSU_MISALIGN_TRAP_EN so the same bench covers both builds.
module tb_dm_lsu;

    localparam int ADDR_W = 5;
`ifdef DM_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              preload;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_type;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [2:0]        mem_type;
    logic              mem_wr;
    logic [31:0]       mem_dout = 32'h0;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    logic [7:0]  dm_mem  [32];
    logic [7:0]  ref_mem [32];
    logic [39:0] wlog [$];

    always #5 clk = ~clk;

    dm_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_type(mem_type),
        .mem_wr(mem_wr), .mem_dout(mem_dout)
    );

    // Memory model: synchronous write, registered read; byte reads sign-extend so the LSU must use only bits 7:0.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) dm_mem[k] <= 8'((k * 37 + 5) % 256);
        end else if (mem_wr) begin
            wlog.push_back({mem_type, mem_addr, mem_din});
            if (mem_type == 3'd0) begin
                for (int k = 0; k < 4; k++) dm_mem[(int'(mem_addr) + k) % 32] <= mem_din[8*k +: 8];
            end else begin
                dm_mem[mem_addr] <= mem_din[7:0];
            end
        end
        if (mem_type == 3'd0) begin
            mem_dout <= {dm_mem[(int'(mem_addr) + 3) % 32], dm_mem[(int'(mem_addr) + 2) % 32],
                         dm_mem[(int'(mem_addr) + 1) % 32], dm_mem[mem_addr]};
        end else begin
            mem_dout <= {{24{dm_mem[mem_addr][7]}}, dm_mem[mem_addr]};
        end
        if (!rst && req_valid && req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int k = 0; k < 32; k++) if (dm_mem[k] !== ref_mem[k]) bad++;
        check(tag, 40'(bad), 40'd0);
    endtask

    // Called at a negedge with the LSU idle; returns at the negedge after the response.
    task automatic run_req(input logic wr, input logic [4:0] addr, input logic [2:0] typ,
                           input logic [31:0] wd, input logic hold);
        int nb, beats, lat_exp, lat, busy_ready, hs0;
        logic err_exp, seen, err_obs;
        logic [31:0] raw, rd_exp, rd_obs;
        logic [39:0] exp_log [$];

        err_exp = (typ > 3'd4);
        if (TRAP && (((typ == 3'd0) && (addr[1:0] != 2'd0)) ||
                     (((typ == 3'd1) || (typ == 3'd2)) && addr[0]))) err_exp = 1'b1;
        nb      = (typ == 3'd0) ? 4 : ((typ <= 3'd2) ? 2 : 1);
        beats   = ((typ == 3'd0) && (addr[1:0] == 2'd0)) ? 1 : nb;
        lat_exp = err_exp ? 1 : (wr ? beats + 1 : beats + 2);

        rd_exp = 32'h0;
        if (!err_exp && !wr) begin
            raw = 32'h0;
            for (int i = 0; i < nb; i++) raw = raw | (32'(ref_mem[(int'(addr) + i) % 32]) << (8 * i));
            rd_exp = raw;
            if ((typ == 3'd1) && raw[15]) rd_exp = raw | 32'hFFFF_0000;
            if ((typ == 3'd3) && raw[7])  rd_exp = raw | 32'hFFFF_FF00;
        end
        if (!err_exp && wr) begin
            if (beats == 1 && typ == 3'd0) begin
                exp_log.push_back({3'd0, addr, wd});
            end else begin
                for (int i = 0; i < nb; i++) exp_log.push_back({3'd3, 5'(addr + 5'(i)), 24'h0, wd[8*i +: 8]});
            end
            for (int i = 0; i < nb; i++) ref_mem[(int'(addr) + i) % 32] = wd[8*i +: 8];
        end

        wlog.delete();
        hs0 = hs_cnt;
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_type = typ; req_wdata = wd;
        seen = 1'b0; lat = 0; busy_ready = 0; rd_obs = 32'h0; err_obs = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1; lat = k; rd_obs = rsp_rdata; err_obs = rsp_err;
                req_valid = 1'b0;
            end else if (req_ready) begin
                busy_ready++;
            end
            if (k == 1) begin
                if (!hold) req_valid = 1'b0;
                req_wr = ~wr; req_addr = 5'($urandom); req_type = 3'($urandom); req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        check("rsp_seen", 40'(seen), 40'd1);
        check("latency", 40'(lat), 40'(lat_exp));
        check("rsp_err", 40'(err_obs), 40'(err_exp));
        check("rsp_rdata", 40'(rd_obs), 40'(rd_exp));
        check("ready_busy", 40'(busy_ready), 40'd0);
        check("handshakes", 40'(hs_cnt - hs0), 40'd1);
        check("write_count", 40'(wlog.size()), 40'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < wlog.size(); i++) check("write_beat", wlog[i], exp_log[i]);
        mem_compare("mem_contents");
        @(negedge clk);
        check("rsp_pulse", {7'd0, rsp_valid, rsp_err, rsp_rdata}, 40'd0);
        check("ready_back", 40'(req_ready), 40'd1);
    endtask

    initial begin
        logic [31:0] wd;
        int rsp_cnt;
        for (int k = 0; k < 32; k++) ref_mem[k] = 8'((k * 37 + 5) % 256);
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 5'd0; req_type = 3'd0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        check("reset_ready", 40'(req_ready), 40'd1);
        check("reset_rsp", {7'd0, rsp_valid, rsp_err, rsp_rdata}, 40'd0);
        check("reset_mem", {mem_wr, mem_type, mem_addr, mem_din}, 40'd0);
        rst = 1'b0;
        @(negedge clk);

        run_req(1'b1, 5'd0,  3'd0, 32'hDEAD_BEEF, 1'b0);
        run_req(1'b0, 5'd0,  3'd0, 32'h0, 1'b0);
        run_req(1'b1, 5'd6,  3'd1, 32'h5555_8001, 1'b0);
        run_req(1'b0, 5'd6,  3'd1, 32'h0, 1'b0);
        run_req(1'b0, 5'd6,  3'd2, 32'h0, 1'b0);
        run_req(1'b0, 5'd7,  3'd3, 32'h0, 1'b0);
        run_req(1'b1, 5'd30, 3'd0, 32'h1122_3344, 1'b0);
        run_req(1'b0, 5'd30, 3'd0, 32'h0, 1'b0);
        run_req(1'b0, 5'd2,  3'd0, 32'h0, 1'b0);
        run_req(1'b0, 5'd4,  3'd7, 32'h0, 1'b0);
        run_req(1'b1, 5'd4,  3'd5, 32'hCAFE_F00D, 1'b0);
        run_req(1'b1, 5'd13, 3'd1, 32'h0000_A5C3, 1'b1);
        run_req(1'b0, 5'd31, 3'd2, 32'h0, 1'b1);

        for (int t = 0; t < 150; t++) begin
            run_req(1'($urandom), 5'($urandom),
                    ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                    $urandom, 1'($urandom));
        end

`ifndef DM_LSU_MISALIGN_TRAP_EN
        // Reset during beat 1 of a split word store: only the first two bytes land.
        wlog.delete();
        wd = $urandom;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd9; req_type = 3'd0; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_beat0_wr", 40'(mem_wr), 40'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_memwr", 40'(mem_wr), 40'd0);
        check("rst_ready", 40'(req_ready), 40'd1);
        rst = 1'b0;
        rsp_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid || mem_wr) rsp_cnt++;
        end
        check("rst_no_rsp", 40'(rsp_cnt), 40'd0);
        ref_mem[9]  = wd[7:0];
        ref_mem[10] = wd[15:8];
        check("rst_writes", 40'(wlog.size()), 40'd2);
        mem_compare("rst_mem");
        run_req(1'b0, 5'd9, 3'd0, 32'h0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
